// File: rtl/bp_lce_to_io_link.sv
`default_nettype none
// ============================================================================
//  Module   : bp_lce_to_io_link
//  Purpose  : Converts uncached LCE requests into I/O link commands. It tracks
//             in-flight requests in order, so each I/O response is returned to
//             its requesting LCE as a store-done or uncached-data command.
//  Option   : BP_LCE_TO_IO_LINK_CHECK_EN enables the sticky protocol checker
//             on error_o. Without it, error_o is tied to 0.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Message layouts (MSB first):
//    lce_req : msg_type[3] src_id[L] addr[P] size[3] data[64]
//    mem msg : msg_type[4] addr[P] size[3] payload[16] data[64]
//    lce_cmd : msg_type[4] dst_id[L] addr[P] size[3] data[64]
//    L = 4 LCE id bits; P = 40 paddr bits (e_bp_inv_cfg) or 56 otherwise
// ============================================================================
module bp_lce_to_io_link #(
    localparam int e_bp_default_cfg = 0,
    localparam int e_bp_inv_cfg     = 1,
    parameter int  bp_params_p       = e_bp_inv_cfg,
    parameter int  outstanding_els_p = 4,
    localparam int paddr_width_lp    = (bp_params_p == e_bp_inv_cfg) ? 40 : 56,
    localparam int lce_id_width_lp   = 4,
    localparam int data_width_lp     = 64,
    localparam int payload_width_lp  = 16,
    localparam int lce_cce_block_req_width_lp = 3 + lce_id_width_lp + paddr_width_lp + 3 + data_width_lp,
    localparam int cce_mem_msg_width_lp       = 4 + paddr_width_lp + 3 + payload_width_lp + data_width_lp,
    localparam int lce_cmd_width_lp           = 4 + lce_id_width_lp + paddr_width_lp + 3 + data_width_lp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [lce_cce_block_req_width_lp-1:0] lce_req_i,
    input  logic                                  lce_req_v_i,
    output logic                                  lce_req_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0]       io_cmd_o,
    output logic                                  io_cmd_v_o,
    input  logic                                  io_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0]       io_resp_i,
    input  logic                                  io_resp_v_i,
    output logic                                  io_resp_yumi_o,

    output logic [lce_cmd_width_lp-1:0]           lce_cmd_o,
    output logic                                  lce_cmd_v_o,
    input  logic                                  lce_cmd_ready_i,

    output logic                                  error_o
);

    localparam int ptr_width_lp = $clog2(outstanding_els_p);
    localparam int cnt_width_lp = ptr_width_lp + 1;
    localparam logic [cnt_width_lp-1:0] full_count_lp = cnt_width_lp'(outstanding_els_p);

    localparam logic [2:0] lce_req_uc_rd_lp  = 3'd2;
    localparam logic [2:0] lce_req_uc_wr_lp  = 3'd3;
    localparam logic [3:0] mem_uc_rd_lp      = 4'd2;
    localparam logic [3:0] mem_uc_wr_lp      = 4'd3;
    localparam logic [3:0] cmd_uc_st_done_lp = 4'd7;
    localparam logic [3:0] cmd_uc_data_lp    = 4'd9;

    typedef struct packed {
        logic [2:0]                 msg_type;
        logic [lce_id_width_lp-1:0] src_id;
        logic [paddr_width_lp-1:0]  addr;
        logic [2:0]                 size;
        logic [data_width_lp-1:0]   data;
    } lce_req_s;

    typedef struct packed {
        logic [3:0]                  msg_type;
        logic [paddr_width_lp-1:0]   addr;
        logic [2:0]                  size;
        logic [payload_width_lp-1:0] payload;
        logic [data_width_lp-1:0]    data;
    } mem_msg_s;

    typedef struct packed {
        logic [3:0]                 msg_type;
        logic [lce_id_width_lp-1:0] dst_id;
        logic [paddr_width_lp-1:0]  addr;
        logic [2:0]                 size;
        logic [data_width_lp-1:0]   data;
    } lce_cmd_s;

    lce_req_s req;
    mem_msg_s resp;
    mem_msg_s io_cmd_r, io_cmd_n;
    lce_cmd_s lce_cmd_r, lce_cmd_n;
    logic     io_cmd_v_r, lce_cmd_v_r;

    assign req  = lce_req_i;
    assign resp = io_resp_i;

    // Tracker: in-order record of requests awaiting a response
    logic [lce_id_width_lp-1:0] trk_src  [outstanding_els_p];
    logic                       trk_wr   [outstanding_els_p];
    logic [paddr_width_lp-1:0]  trk_addr [outstanding_els_p];
    logic [2:0]                 trk_size [outstanding_els_p];
    logic [ptr_width_lp-1:0]    wptr, rptr;
    logic [cnt_width_lp-1:0]    count;

    logic trk_full, trk_empty;
    logic is_uc, req_wr, push, pop, drop;
    logic io_cmd_free, lce_cmd_free;

    assign trk_full  = (count == full_count_lp);
    assign trk_empty = (count == '0);

    assign is_uc  = (req.msg_type == lce_req_uc_rd_lp) || (req.msg_type == lce_req_uc_wr_lp);
    assign req_wr = (req.msg_type == lce_req_uc_wr_lp);

    // A held command may be replaced in the same cycle it is handed off
    assign io_cmd_free  = ~io_cmd_v_r  | io_cmd_ready_i;
    assign lce_cmd_free = ~lce_cmd_v_r | lce_cmd_ready_i;

    // Occupancy is taken from the registered count only, so a pop never frees
    // room for a push in the same cycle and a push is never popped same-cycle.
    assign lce_req_yumi_o = ~reset_i & lce_req_v_i & io_cmd_free & ~trk_full;
    assign io_resp_yumi_o = ~reset_i & io_resp_v_i & ~trk_empty & lce_cmd_free;

    assign push = lce_req_yumi_o & is_uc;
    assign drop = lce_req_yumi_o & ~is_uc;
    assign pop  = io_resp_yumi_o;

    logic [lce_id_width_lp-1:0] head_src;
    logic                       head_wr;
    logic [paddr_width_lp-1:0]  head_addr;
    logic [2:0]                 head_size;

    assign head_src  = trk_src[rptr];
    assign head_wr   = trk_wr[rptr];
    assign head_addr = trk_addr[rptr];
    assign head_size = trk_size[rptr];

    // Tracker pointers and occupancy
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tracker storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            trk_src[wptr]  <= req.src_id;
            trk_wr[wptr]   <= req_wr;
            trk_addr[wptr] <= req.addr;
            trk_size[wptr] <= req.size;
        end
    end

    // Next I/O command built from the accepted request
    always_comb begin
        io_cmd_n          = '0;
        io_cmd_n.msg_type = req_wr ? mem_uc_wr_lp : mem_uc_rd_lp;
        io_cmd_n.addr     = req.addr;
        io_cmd_n.size     = req.size;
        io_cmd_n.data     = req.data;
    end

    // I/O command holding register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            io_cmd_v_r <= 1'b0;
            io_cmd_r   <= '0;
        end else if (push) begin
            io_cmd_v_r <= 1'b1;
            io_cmd_r   <= io_cmd_n;
        end else if (io_cmd_ready_i) begin
            io_cmd_v_r <= 1'b0;
        end
    end

    // Next LCE command built from the response and the tracker head
    always_comb begin
        lce_cmd_n          = '0;
        lce_cmd_n.msg_type = head_wr ? cmd_uc_st_done_lp : cmd_uc_data_lp;
        lce_cmd_n.dst_id   = head_src;
        lce_cmd_n.addr     = resp.addr;
        lce_cmd_n.size     = resp.size;
        lce_cmd_n.data     = resp.data;
    end

    // LCE command holding register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lce_cmd_v_r <= 1'b0;
            lce_cmd_r   <= '0;
        end else if (pop) begin
            lce_cmd_v_r <= 1'b1;
            lce_cmd_r   <= lce_cmd_n;
        end else if (lce_cmd_ready_i) begin
            lce_cmd_v_r <= 1'b0;
        end
    end

    assign io_cmd_o    = io_cmd_r;
    assign io_cmd_v_o  = io_cmd_v_r;
    assign lce_cmd_o   = lce_cmd_r;
    assign lce_cmd_v_o = lce_cmd_v_r;

`ifdef BP_LCE_TO_IO_LINK_CHECK_EN
    logic       error_r;
    logic       err_event;
    logic [3:0] head_mem_type;

    assign head_mem_type = head_wr ? mem_uc_wr_lp : mem_uc_rd_lp;
    assign err_event = (io_resp_v_i & trk_empty)
                     | (pop & (resp.addr != head_addr))
                     | (pop & (resp.msg_type != head_mem_type))
                     | drop;

    // Sticky protocol-error flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)        error_r <= 1'b0;
        else if (err_event) error_r <= 1'b1;
    end

    assign error_o = error_r;

    logic unused_bits;
    assign unused_bits = ^{resp.payload, head_size};
`else
    assign error_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{resp.msg_type, resp.payload, head_addr, head_size, drop};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_lce_to_io_link.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_lce_to_io_link
//  Purpose  : Self-checking bench for bp_lce_to_io_link (default config,
//             4 outstanding entries). A queue-based reference model is
//             compared on every falling edge; directed steps add literal
//             checks for the key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_lce_to_io_link;

    localparam int REQ_W = 114;
    localparam int MEM_W = 127;
    localparam int CMD_W = 115;
    localparam int DEPTH = 4;
`ifdef BP_LCE_TO_IO_LINK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REQ_W-1:0] lce_req_i = '0;
    logic             lce_req_v_i = 1'b0;
    logic             lce_req_yumi_o;
    logic [MEM_W-1:0] io_cmd_o;
    logic             io_cmd_v_o;
    logic             io_cmd_ready_i = 1'b1;
    logic [MEM_W-1:0] io_resp_i = '0;
    logic             io_resp_v_i = 1'b0;
    logic             io_resp_yumi_o;
    logic [CMD_W-1:0] lce_cmd_o;
    logic             lce_cmd_v_o;
    logic             lce_cmd_ready_i = 1'b1;
    logic             error_o;

    bp_lce_to_io_link #(.outstanding_els_p(DEPTH)) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .lce_req_i      (lce_req_i),
        .lce_req_v_i    (lce_req_v_i),
        .lce_req_yumi_o (lce_req_yumi_o),
        .io_cmd_o       (io_cmd_o),
        .io_cmd_v_o     (io_cmd_v_o),
        .io_cmd_ready_i (io_cmd_ready_i),
        .io_resp_i      (io_resp_i),
        .io_resp_v_i    (io_resp_v_i),
        .io_resp_yumi_o (io_resp_yumi_o),
        .lce_cmd_o      (lce_cmd_o),
        .lce_cmd_v_o    (lce_cmd_v_o),
        .lce_cmd_ready_i(lce_cmd_ready_i),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  src;
        bit          wr;
        logic [39:0] addr;
    } trk_t;

    trk_t             trk[$];
    logic             m_io_v = 1'b0, m_lc_v = 1'b0, m_err = 1'b0;
    logic [MEM_W-1:0] m_io = '0;
    logic [CMD_W-1:0] m_lc = '0;
    bit               ry, py;
    trk_t             ent, hd;
    logic [2:0]       rtype;
    logic [3:0]       mtype;

    function automatic bit exp_req_yumi();
        return !rst && lce_req_v_i && (!m_io_v || io_cmd_ready_i) && (trk.size() < DEPTH);
    endfunction

    function automatic bit exp_resp_yumi();
        return !rst && io_resp_v_i && (trk.size() > 0) && (!m_lc_v || lce_cmd_ready_i);
    endfunction

    // Model state advances on each rising edge; reset clears it at once
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            trk.delete();
            m_io_v = 1'b0;
            m_lc_v = 1'b0;
            m_err  = 1'b0;
        end else begin
            ry = exp_req_yumi();
            py = exp_resp_yumi();
            if (CHK && io_resp_v_i && trk.size() == 0) m_err = 1'b1;
            if (m_io_v && io_cmd_ready_i) m_io_v = 1'b0;
            if (ry) begin
                rtype = lce_req_i[113:111];
                if (rtype == 3'd2 || rtype == 3'd3) begin
                    mtype    = (rtype == 3'd3) ? 4'd3 : 4'd2;
                    m_io     = {mtype, lce_req_i[106:67], lce_req_i[66:64], 16'h0, lce_req_i[63:0]};
                    m_io_v   = 1'b1;
                    ent.src  = lce_req_i[110:107];
                    ent.wr   = (rtype == 3'd3);
                    ent.addr = lce_req_i[106:67];
                    trk.push_back(ent);
                end else if (CHK) begin
                    m_err = 1'b1;
                end
            end
            if (m_lc_v && lce_cmd_ready_i) m_lc_v = 1'b0;
            if (py) begin
                hd     = trk.pop_front();
                mtype  = hd.wr ? 4'd7 : 4'd9;
                m_lc   = {mtype, hd.src, io_resp_i[122:83], io_resp_i[82:80], io_resp_i[63:0]};
                m_lc_v = 1'b1;
                if (CHK && ((io_resp_i[122:83] != hd.addr) ||
                            (io_resp_i[126:123] != (hd.wr ? 4'd3 : 4'd2)))) m_err = 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        chk("req_yumi", lce_req_yumi_o, exp_req_yumi());
        chk("resp_yumi", io_resp_yumi_o, exp_resp_yumi());
        chk("io_cmd_v", io_cmd_v_o, m_io_v);
        if (m_io_v) chk("io_cmd", io_cmd_o, m_io);
        chk("lce_cmd_v", lce_cmd_v_o, m_lc_v);
        if (m_lc_v) chk("lce_cmd", lce_cmd_o, m_lc);
        chk("error", error_o, m_err);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [2:0] t, input logic [3:0] src, input logic [39:0] a,
                            input logic [63:0] d);
        bit got = 0;
        lce_req_i   = {t, src, a, 3'd3, d};
        lce_req_v_i = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (lce_req_yumi_o) got = 1;
        end
        if (!got) chk("req_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        lce_req_v_i = 1'b0;
    endtask

    task automatic send_resp(input logic [3:0] t, input logic [39:0] a, input logic [63:0] d);
        bit got = 0;
        io_resp_i   = {t, a, 3'd3, 16'h0, d};
        io_resp_v_i = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (io_resp_yumi_o) got = 1;
        end
        if (!got) chk("resp_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        io_resp_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rs, ps, grs, gps;
        // Reset state, with a request pending that must not be taken
        lce_req_i   = {3'd2, 4'd0, 40'h0, 3'd3, 64'h0};
        lce_req_v_i = 1'b1;
        @(negedge clk);
        chk("rst_io_cmd_v", io_cmd_v_o, 1'b0);
        chk("rst_lce_cmd_v", lce_cmd_v_o, 1'b0);
        chk("rst_req_yumi", lce_req_yumi_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        @(posedge clk); #1;
        lce_req_v_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // uc_rd 0x8000_0040 from src 2
        send_req(3'd2, 4'd2, 40'h80_0000_0040, 64'h0);
        chk("rd_io_cmd_v", io_cmd_v_o, 1'b1);
        chk("rd_io_cmd_type", io_cmd_o[126:123], 4'd2);
        chk("rd_io_cmd_addr", io_cmd_o[122:83], 40'h80_0000_0040);
        send_resp(4'd2, 40'h80_0000_0040, 64'h1122_3344_5566_7788);
        chk("rd_lce_cmd_v", lce_cmd_v_o, 1'b1);
        chk("rd_lce_cmd_type", lce_cmd_o[114:111], 4'd9);
        chk("rd_lce_cmd_dst", lce_cmd_o[110:107], 4'd2);
        chk("rd_lce_cmd_data", lce_cmd_o[63:0], 64'h1122_3344_5566_7788);

        // uc_wr data 0xDEAD_BEEF from src 1
        send_req(3'd3, 4'd1, 40'h80_0000_0080, 64'hDEAD_BEEF);
        chk("wr_io_cmd_type", io_cmd_o[126:123], 4'd3);
        chk("wr_io_cmd_data", io_cmd_o[63:0], 64'hDEAD_BEEF);
        send_resp(4'd3, 40'h80_0000_0080, 64'h0);
        chk("wr_lce_cmd_type", lce_cmd_o[114:111], 4'd7);
        chk("wr_lce_cmd_dst", lce_cmd_o[110:107], 4'd1);
        repeat (2) @(posedge clk);
        #1;

        // Fill the tracker; the fifth read waits for the first response
        for (int i = 0; i < 4; i++)
            send_req(3'd2, 4'(i), 40'h100 + 40'(i * 8), 64'(i));
        lce_req_i   = {3'd2, 4'd4, 40'h200, 3'd3, 64'h0};
        lce_req_v_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_req_yumi", lce_req_yumi_o, 1'b0);
        end
        @(posedge clk); #1;
        io_resp_i   = {4'd2, 40'h100, 3'd3, 16'h0, 64'hA0};
        io_resp_v_i = 1'b1;
        @(negedge clk);
        chk("full_pop_resp_yumi", io_resp_yumi_o, 1'b1);
        chk("full_no_bypass", lce_req_yumi_o, 1'b0);
        @(posedge clk); #1;
        io_resp_v_i = 1'b0;
        @(negedge clk);
        chk("after_pop_req_yumi", lce_req_yumi_o, 1'b1);
        @(posedge clk); #1;
        lce_req_v_i = 1'b0;
        send_resp(4'd2, 40'h108, 64'hA1);
        send_resp(4'd2, 40'h110, 64'hA2);
        send_resp(4'd2, 40'h118, 64'hA3);
        send_resp(4'd2, 40'h200, 64'hA4);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure on both command outputs for 10 cycles
        send_req(3'd2, 4'd3, 40'h300, 64'h0);
        send_req(3'd2, 4'd3, 40'h308, 64'h0);
        @(posedge clk); #1;
        io_cmd_ready_i = 1'b0;
        send_req(3'd2, 4'd3, 40'h310, 64'h0);
        lce_cmd_ready_i = 1'b0;
        send_resp(4'd2, 40'h300, 64'hC0FFEE);
        lce_req_i   = {3'd2, 4'd3, 40'h318, 3'd3, 64'h0};
        lce_req_v_i = 1'b1;
        io_resp_i   = {4'd2, 40'h308, 3'd3, 16'h0, 64'hB1};
        io_resp_v_i = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_req_yumi", lce_req_yumi_o, 1'b0);
            chk("bp_resp_yumi", io_resp_yumi_o, 1'b0);
            chk("bp_io_cmd", io_cmd_o, {4'd2, 40'h310, 3'd3, 16'h0, 64'h0});
            chk("bp_lce_cmd", lce_cmd_o, {4'd9, 4'd3, 40'h300, 3'd3, 64'hC0FFEE});
        end
        @(posedge clk); #1;
        io_cmd_ready_i  = 1'b1;
        lce_cmd_ready_i = 1'b1;
        grs = 0;
        gps = 0;
        for (int i = 0; i < 20 && !(grs && gps); i++) begin
            @(negedge clk);
            rs = lce_req_yumi_o;
            ps = io_resp_yumi_o;
            @(posedge clk); #1;
            if (rs) begin lce_req_v_i = 1'b0; grs = 1; end
            if (ps) begin io_resp_v_i = 1'b0; gps = 1; end
        end
        if (!(grs && gps)) chk("bp_release_timeout", 1'b0, 1'b1);
        lce_req_v_i = 1'b0;
        io_resp_v_i = 1'b0;
        send_resp(4'd2, 40'h310, 64'hB2);
        send_resp(4'd2, 40'h318, 64'hB3);
        repeat (2) @(posedge clk);
        #1;

        // Response with nothing outstanding
        io_resp_i   = {4'd2, 40'h500, 3'd3, 16'h0, 64'h0};
        io_resp_v_i = 1'b1;
        @(negedge clk);
        chk("empty_resp_yumi", io_resp_yumi_o, 1'b0);
        @(posedge clk); #1;
        chk("empty_resp_error", error_o, CHK);
        repeat (3) begin
            @(negedge clk);
            chk("empty_resp_error_hold", error_o, CHK);
        end
        @(posedge clk); #1;
        io_resp_v_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("error_cleared", error_o, 1'b0);
        @(posedge clk); #1;

        // Non-uncached request is accepted and dropped
        send_req(3'd0, 4'd5, 40'h400, 64'h0);
        chk("drop_io_cmd_v", io_cmd_v_o, 1'b0);
        chk("drop_error", error_o, CHK);

        // Reset mid-stream with three requests outstanding
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_req(3'd2, 4'd6, 40'h600, 64'h0);
        send_req(3'd2, 4'd6, 40'h608, 64'h0);
        send_req(3'd2, 4'd6, 40'h610, 64'h0);
        io_cmd_ready_i = 1'b0;
        lce_req_i      = {3'd2, 4'd6, 40'h618, 3'd3, 64'h0};
        lce_req_v_i    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_io_cmd_v", io_cmd_v_o, 1'b0);
        chk("midrst_lce_cmd_v", lce_cmd_v_o, 1'b0);
        chk("midrst_req_yumi", lce_req_yumi_o, 1'b0);
        chk("midrst_resp_yumi", io_resp_yumi_o, 1'b0);
        @(posedge clk); #1;
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b1;
        rst = 1'b0;
        io_resp_i   = {4'd2, 40'h600, 3'd3, 16'h0, 64'h0};
        io_resp_v_i = 1'b1;
        @(negedge clk);
        chk("postrst_tracker_empty", io_resp_yumi_o, 1'b0);
        @(posedge clk); #1;
        io_resp_v_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
